// File: rtl/channel_scanner_8x16.sv
// channel_scanner_8x16
// Sweeps the enabled inputs of an external 8:1 16-bit mux in ascending
// channel order. Each channel takes two cycles: one settle cycle with the
// new select applied (SELECT), then a capture of mux_y (CAPTURE). The block
// runs a single sweep or repeats sweeps until aborted. All outputs are
// registered.
//
// Handshake: no valid/ready flow control. data_valid is a one-cycle
// strobe and data_out/chan_out are only meaningful in that cycle. done
// pulses once at the end of a single sweep, or in response to a start
// with an empty mask.
module channel_scanner_8x16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        continuous,
    input  logic [7:0]  mask,
    input  logic        abort,
    input  logic [15:0] mux_y,
    output logic [2:0]  sel,
    output logic [15:0] data_out,
    output logic [2:0]  chan_out,
    output logic        data_valid,
    output logic        busy,
    output logic        done,
    output logic [7:0]  sweep_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  mask_q, mask_nx;
    logic        cont_q, cont_nx;
    logic [2:0]  sel_nx;
    logic [15:0] data_out_nx;
    logic [2:0]  chan_out_nx;
    logic        data_valid_nx;
    logic        done_nx;
    logic [7:0]  sweep_nx;
    logic        found_higher;
    logic [2:0]  higher_idx;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Lowest set bit strictly above cur: {found, index}.
    function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] cur);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    assign {found_higher, higher_idx} = next_above(mask_q, sel);

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_nx      = state;
        mask_nx       = mask_q;
        cont_nx       = cont_q;
        sel_nx        = sel;
        data_out_nx   = data_out;
        chan_out_nx   = chan_out;
        data_valid_nx = 1'b0;
        done_nx       = 1'b0;
        sweep_nx      = sweep_count;
        case (state)
            IDLE: begin
                // abort outranks start so a coincident pair never launches a scan
                if (start && !abort) begin
                    if (mask != 8'd0) begin
                        mask_nx  = mask;
                        cont_nx  = continuous;
                        sel_nx   = lowest_bit(mask);
                        state_nx = SELECT;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            SELECT: begin
                state_nx = abort ? IDLE : CAPTURE;
            end
            CAPTURE: begin
                if (abort) begin
                    state_nx = IDLE;
                end else begin
                    data_out_nx   = mux_y;
                    chan_out_nx   = sel;
                    data_valid_nx = 1'b1;
                    if (found_higher) begin
                        sel_nx   = higher_idx;
                        state_nx = SELECT;
                    end else begin
                        sweep_nx = sweep_count + 8'd1;
                        if (cont_q) begin
                            sel_nx   = lowest_bit(mask_q);
                            state_nx = SELECT;
                        end else begin
                            done_nx  = 1'b1;
                            state_nx = IDLE;
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mask_q      <= 8'd0;
            cont_q      <= 1'b0;
            sel         <= 3'd0;
            data_out    <= 16'd0;
            chan_out    <= 3'd0;
            data_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sweep_count <= 8'd0;
        end else begin
            state       <= state_nx;
            mask_q      <= mask_nx;
            cont_q      <= cont_nx;
            sel         <= sel_nx;
            data_out    <= data_out_nx;
            chan_out    <= chan_out_nx;
            data_valid  <= data_valid_nx;
            busy        <= (state_nx != IDLE);
            done        <= done_nx;
            sweep_count <= sweep_nx;
        end
    end

endmodule

// File: tb/tb_channel_scanner_8x16.sv
// Directed bench for channel_scanner_8x16 with a behavioural 8:1 mux
// returning 16'h1000 + sel.
module tb_channel_scanner_8x16;

    logic        clk;
    logic        rst;
    logic        start;
    logic        continuous;
    logic [7:0]  mask;
    logic        abort;
    logic [15:0] mux_y;
    logic [2:0]  sel;
    logic [15:0] data_out;
    logic [2:0]  chan_out;
    logic        data_valid;
    logic        busy;
    logic        done;
    logic [7:0]  sweep_count;

    int check_cnt = 0;
    int pass_cnt  = 0;
    logic [7:0] exp_sweep;

    channel_scanner_8x16 dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .mask(mask), .abort(abort), .mux_y(mux_y), .sel(sel),
        .data_out(data_out), .chan_out(chan_out), .data_valid(data_valid),
        .busy(busy), .done(done), .sweep_count(sweep_count)
    );

    // clock / mux model
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always_comb mux_y = 16'h1000 + {13'd0, sel};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // advance one edge, settle 1ns past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_scan(input logic [7:0] m, input logic c);
        mask = m; continuous = c; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; continuous = 1'b0; mask = 8'd0; abort = 1'b0;
        tick(); tick();
        rst = 1'b0;
        // reset state
        check("rst_sel", 32'(sel), 0);
        check("rst_data", 32'(data_out), 0);
        check("rst_chan", 32'(chan_out), 0);
        check("rst_dv", 32'(data_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sweep", 32'(sweep_count), 0);
        exp_sweep = 8'd0;

        // single sweep, mask 81
        start_scan(8'h81, 1'b0);
        check("s1_busy", 32'(busy), 1);
        check("s1_sel0", 32'(sel), 0);
        tick();
        check("s1_dv_c2", 32'(data_valid), 0);
        tick();
        check("s1_dv_c3", 32'(data_valid), 1);
        check("s1_chan_a", 32'(chan_out), 0);
        check("s1_data_a", 32'(data_out), 32'h1000);
        check("s1_done_a", 32'(done), 0);
        check("s1_sel7", 32'(sel), 7);
        tick();
        check("s1_dv_c4", 32'(data_valid), 0);
        tick();
        exp_sweep++;
        check("s1_dv_c5", 32'(data_valid), 1);
        check("s1_chan_b", 32'(chan_out), 7);
        check("s1_data_b", 32'(data_out), 32'h1007);
        check("s1_done_b", 32'(done), 1);
        check("s1_sweep", 32'(sweep_count), 32'(exp_sweep));
        check("s1_busy_end", 32'(busy), 0);
        tick();
        check("s1_done_clr", 32'(done), 0);
        check("s1_sel_hold", 32'(sel), 7);

        // continuous sweep mask FF, 16 captures, then abort
        start_scan(8'hFF, 1'b1);
        for (int k = 0; k < 16; k++) begin
            tick();
            check("c_dv_gap", 32'(data_valid), 0);
            tick();
            check("c_dv", 32'(data_valid), 1);
            check("c_chan", 32'(chan_out), 32'(k % 8));
            check("c_data", 32'(data_out), 32'h1000 + 32'(k % 8));
            check("c_done", 32'(done), 0);
            if (k % 8 == 7) exp_sweep++;
        end
        check("c_sweep", 32'(sweep_count), 32'(exp_sweep));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("c_abort_busy", 32'(busy), 0);
        check("c_abort_dv", 32'(data_valid), 0);

        // empty mask: done only
        start_scan(8'h00, 1'b0);
        check("m0_done", 32'(done), 1);
        check("m0_busy", 32'(busy), 0);
        check("m0_dv", 32'(data_valid), 0);
        check("m0_sweep", 32'(sweep_count), 32'(exp_sweep));
        tick();
        check("m0_done_clr", 32'(done), 0);

        // continuous mask 24, abort in CAPTURE
        start_scan(8'h24, 1'b1);
        tick(); tick();
        check("ab_dv", 32'(data_valid), 1);
        check("ab_data", 32'(data_out), 32'h1002);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_no_dv", 32'(data_valid), 0);
        check("ab_no_done", 32'(done), 0);
        check("ab_busy", 32'(busy), 0);
        check("ab_data_hold", 32'(data_out), 32'h1002);
        check("ab_chan_hold", 32'(chan_out), 2);
        check("ab_sel_hold", 32'(sel), 5);
        check("ab_sweep", 32'(sweep_count), 32'(exp_sweep));

        // abort and start together in IDLE
        abort = 1'b1;
        start_scan(8'h01, 1'b0);
        abort = 1'b0;
        check("as_busy", 32'(busy), 0);
        check("as_done", 32'(done), 0);
        tick();
        check("as_busy2", 32'(busy), 0);

        // mask F0 single sweep, ignored start, reset mid-sweep
        start_scan(8'hF0, 1'b0);
        tick(); tick();
        check("r_chan4", 32'(chan_out), 4);
        mask = 8'h0F; continuous = 1'b1; start = 1'b1;
        tick(); tick();
        start = 1'b0;
        check("r_chan5", 32'(chan_out), 5);
        check("r_data5", 32'(data_out), 32'h1005);
        check("r_sel6", 32'(sel), 6);
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        exp_sweep = 8'd0;
        check("r_sel", 32'(sel), 0);
        check("r_data", 32'(data_out), 0);
        check("r_chan", 32'(chan_out), 0);
        check("r_dv", 32'(data_valid), 0);
        check("r_busy", 32'(busy), 0);
        check("r_done", 32'(done), 0);
        check("r_sweep", 32'(sweep_count), 0);

        // sweep counter wrap: 256 single sweeps of channel 0
        for (int n = 0; n < 256; n++) begin
            start_scan(8'h01, 1'b0);
            tick(); tick();
            exp_sweep++;
            if (n == 254) check("w_sweep255", 32'(sweep_count), 32'(exp_sweep));
        end
        check("w_sweep_wrap", 32'(sweep_count), 0);
        check("w_done", 32'(done), 1);
        check("w_dv", 32'(data_valid), 1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
